// File: rtl/uart_loader_if.sv
// Memory write-port bundle driven by the UART boot loader.
interface uart_loader_if;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   modport master (output mem_we, mem_addr, mem_wdata);
   modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/uart_loader.sv
// UART boot loader: receives an 8N1 byte stream (16-bit word count header, then
// little-endian words), writes them to memory, then releases the core.
module uart_loader #(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned MEM_WORDS    = 2048,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          uart_rx,
   uart_loader_if.master mem,
   output logic          core_run,
   output logic          busy,
   output logic          error,
   output logic [15:0]   words_loaded
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, DONE, ERR} ld_state_t;

   logic rx_s1, rx_s2, rx_prev;

   rx_state_t   rx_q, rx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shreg_q, shreg_d;
   ld_state_t   ld_q, ld_d;
   logic [15:0] count_q, count_d;
   logic [1:0]  byte_q, byte_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        run_q, run_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic [15:0] words_q, words_d;

   logic        active, byte_ok, frame_err;
   logic [15:0] hdr_n;

   // Two-flop synchronizer plus one delayed copy for start-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= uart_rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_q    <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         ld_q    <= HDR_LO;
         count_q <= '0;
         byte_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
         run_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         words_q <= '0;
      end else begin
         rx_q    <= rx_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         ld_q    <= ld_d;
         count_q <= count_d;
         byte_q  <= byte_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         run_q   <= run_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         words_q <= words_d;
      end
   end

   always_comb begin
      rx_d      = rx_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      ld_d      = ld_q;
      count_d   = count_q;
      byte_d    = byte_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      run_d     = run_q;
      busy_d    = busy_q;
      err_d     = err_q;
      words_d   = words_q;
      byte_ok   = 1'b0;
      frame_err = 1'b0;
      hdr_n     = {shreg_q, count_q[7:0]};
      active    = (ld_q == HDR_LO) || (ld_q == HDR_HI) || (ld_q == DATA);

      // Byte receiver; stays idle once the loader has finished or failed
      case (rx_q)
         RX_IDLE: begin
            if (active && rx_prev && !rx_s2) begin
               rx_d  = RX_START;
               cnt_d = HALF_LAST;
            end
         end
         RX_START: begin
            if (cnt_q == '0) begin
               if (!rx_s2) begin
                  rx_d   = RX_DATA;
                  cnt_d  = BIT_LAST;
                  bit_d  = '0;
                  busy_d = 1'b1;
               end else begin
                  rx_d = RX_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RX_DATA: begin
            if (cnt_q == '0) begin
               shreg_d = {rx_s2, shreg_q[7:1]};
               cnt_d   = BIT_LAST;
               if (bit_q == 3'd7) rx_d = RX_STOP;
               else               bit_d = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RX_STOP: begin
            if (cnt_q == '0) begin
               rx_d      = RX_IDLE;
               byte_ok   = rx_s2;
               frame_err = !rx_s2;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: rx_d = RX_IDLE;
      endcase

      case (ld_q)
         HDR_LO: begin
            if (byte_ok) begin
               count_d[7:0] = shreg_q;
               ld_d         = HDR_HI;
            end
         end
         HDR_HI: begin
            if (byte_ok) begin
               count_d = hdr_n;
               if (hdr_n == 16'd0) begin
                  ld_d   = DONE;
                  run_d  = 1'b1;
                  busy_d = 1'b0;
               end else if (32'(hdr_n) > MEM_WORDS) begin
                  ld_d   = ERR;
                  err_d  = 1'b1;
                  busy_d = 1'b0;
               end else begin
                  ld_d   = DATA;
                  byte_d = '0;
               end
            end
         end
         DATA: begin
            // Count the word once its strobe has gone out; finish on the last one
            if (we_q) begin
               words_d = words_q + 16'd1;
               if (words_q + 16'd1 == count_q) begin
                  ld_d   = DONE;
                  run_d  = 1'b1;
                  busy_d = 1'b0;
               end
            end
            if (byte_ok) begin
               case (byte_q)
                  2'd0:    wdata_d[7:0]   = shreg_q;
                  2'd1:    wdata_d[15:8]  = shreg_q;
                  2'd2:    wdata_d[23:16] = shreg_q;
                  default: wdata_d[31:24] = shreg_q;
               endcase
               byte_d = byte_q + 2'd1;
               if (byte_q == 2'd3) begin
                  we_d   = 1'b1;
                  addr_d = BASE_ADDR + 32'({words_q, 2'b00});
               end
            end
         end
         default: ;
      endcase

      if (frame_err && active) begin
         ld_d   = ERR;
         err_d  = 1'b1;
         busy_d = 1'b0;
         run_d  = 1'b0;
         we_d   = 1'b0;
      end
   end

   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign core_run      = run_q;
   assign busy          = busy_q;
   assign error         = err_q;
   assign words_loaded  = words_q;

endmodule
